// File: rtl/video_sync_decoder.sv
// Receive-side sync decoder: recovers pixel position from raw hsync/vsync and tracks timing lock.
// Define VIDEO_SYNC_DECODER_STATS_EN to add frame and sync-error counters.
module video_sync_decoder #(
    parameter int unsigned H_VISIBLE       = 640,
    parameter int unsigned H_FP            = 16,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_TOTAL         = 800,
    parameter int unsigned V_VISIBLE       = 480,
    parameter int unsigned V_FP            = 10,
    parameter int unsigned V_TOTAL         = 525,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [2:0]  i_rgb,
    output logic [9:0]  o_hpos,
    output logic [9:0]  o_vpos,
    output logic        o_visible,
    output logic [2:0]  o_rgb,
    output logic        o_locked,
    output logic        o_frame_start,
    output logic        o_sync_err
`ifdef VIDEO_SYNC_DECODER_STATS_EN
    ,
    output logic [15:0] o_frame_count,
    output logic [7:0]  o_err_count
`endif
);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_VISIBLE + H_FP + H_SYNC > H_TOTAL
        || V_VISIBLE + V_FP >= V_TOTAL) begin : g_bad_params
        $error("video_sync_decoder: inconsistent timing parameters");
    end

    localparam logic [9:0] HsPos = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] VsLine = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] HLast = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast = 10'(V_TOTAL - 1);
    localparam logic [9:0] HVis = 10'(H_VISIBLE);
    localparam logic [9:0] VVis = 10'(V_VISIBLE);

    typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

    logic       hs_n, vs_n;
    logic       hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [2:0] rgb_q;
    logic [9:0] h_cnt_q, v_cnt_q;
    state_e     state_q;
    logic       err_seen_q;
    logic [9:0] hpos_q, vpos_q;
    logic       visible_q, locked_q, frame_start_q, sync_err_q;
    logic [2:0] out_rgb_q;

    logic       h_wrap, hs_edge, vs_edge, h_err, v_err;
    logic [9:0] h_nom, v_nom, h_d, v_d;
    state_e     state_d;
    logic       err_seen_d, locked_d, visible_d, frame_start_d, sync_err_d;

    assign hs_n = (SYNC_ACTIVE_LOW != 0) ? ~i_hsync : i_hsync;
    assign vs_n = (SYNC_ACTIVE_LOW != 0) ? ~i_vsync : i_vsync;

    always_comb begin
        h_wrap  = (h_cnt_q == HLast);
        h_nom   = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_nom   = v_cnt_q;
        if (h_wrap) begin
            v_nom = (v_cnt_q == VLast) ? 10'd0 : v_cnt_q + 10'd1;
        end
        hs_edge = hs_q & ~hs_prev_q;
        vs_edge = vs_q & ~vs_prev_q;
        // Errors are judged against the free-running position, edge present xor edge expected.
        h_err   = hs_edge != (h_nom == HsPos);
        v_err   = vs_edge != ((v_nom == VsLine) && (h_nom == 10'd0));

        h_d = h_nom;
        v_d = v_nom;
        if (state_q != StLocked) begin
            if (hs_edge) h_d = HsPos;
            if (vs_edge) v_d = VsLine;
        end

        state_d    = state_q;
        err_seen_d = err_seen_q;
        case (state_q)
            StSearch: begin
                if (vs_edge) begin
                    state_d    = StTrack;
                    err_seen_d = 1'b0;
                end
            end
            StTrack: begin
                err_seen_d = err_seen_q | h_err | v_err;
                if (vs_edge) begin
                    if (!err_seen_q && !h_err && !v_err) begin
                        state_d = StLocked;
                    end
                    err_seen_d = 1'b0;
                end
            end
            StLocked: begin
                if (h_err || v_err) state_d = StSearch;
            end
            default: state_d = StSearch;
        endcase

        locked_d      = (state_d == StLocked);
        visible_d     = locked_d && (h_d < HVis) && (v_d < VVis);
        frame_start_d = locked_d && (h_d == 10'd0) && (v_d == 10'd0);
        sync_err_d    = (state_q == StLocked) && (h_err || v_err);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            rgb_q         <= 3'd0;
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            state_q       <= StSearch;
            err_seen_q    <= 1'b0;
            hpos_q        <= 10'd0;
            vpos_q        <= 10'd0;
            visible_q     <= 1'b0;
            out_rgb_q     <= 3'd0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            hs_q          <= hs_n;
            vs_q          <= vs_n;
            hs_prev_q     <= hs_q;
            vs_prev_q     <= vs_q;
            rgb_q         <= i_rgb;
            h_cnt_q       <= h_d;
            v_cnt_q       <= v_d;
            state_q       <= state_d;
            err_seen_q    <= err_seen_d;
            hpos_q        <= h_d;
            vpos_q        <= v_d;
            visible_q     <= visible_d;
            out_rgb_q     <= visible_d ? rgb_q : 3'd0;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign o_hpos        = hpos_q;
    assign o_vpos        = vpos_q;
    assign o_visible     = visible_q;
    assign o_rgb         = out_rgb_q;
    assign o_locked      = locked_q;
    assign o_frame_start = frame_start_q;
    assign o_sync_err    = sync_err_q;

`ifdef VIDEO_SYNC_DECODER_STATS_EN
    logic [15:0] frame_count_q;
    logic [7:0]  err_count_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            frame_count_q <= 16'd0;
            err_count_q   <= 8'd0;
        end else begin
            if (frame_start_d) frame_count_q <= frame_count_q + 16'd1;
            if (sync_err_d && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
        end
    end

    assign o_frame_count = frame_count_q;
    assign o_err_count   = err_count_q;
`endif

endmodule
